// File: rtl/cordic_normalizer_if.sv
// Operand and result handshake bundle for the leading-sign normalizer.
// The slave modport is the normalizer side and the master modport is the producer/consumer side.
interface cordic_normalizer_if #(
    parameter int Width = 16
);
    logic [Width-1:0] x_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] y_o;
    logic [3:0]       amount_o;
    logic             norm_o;
    logic             valid_o;
    logic             ready_i;

    modport slave (
        input  x_i, valid_i, ready_i,
        output ready_o, y_o, amount_o, norm_o, valid_o
    );

    modport master (
        output x_i, valid_i, ready_i,
        input  ready_o, y_o, amount_o, norm_o, valid_o
    );
endinterface

// File: rtl/cordic_normalizer.sv
// Sequential leading-sign normalizer: left-shifts out redundant sign bits in binary stages 8/4/2/1.
// It reports the applied count, so an arithmetic right shift by that count restores the operand.
//
// state  | meaning
// S_IDLE | ready_o high, waiting for an operand
// S_BUSY | applying stage k (shift 2^k), k = 3..0
// S_DONE | valid_o high, holding the result until ready_i
module cordic_normalizer #(
    parameter int Width = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cordic_normalizer_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_k;
    logic [Width-1:0] r_data;
    logic [3:0]       r_amount;

    logic [3:0]       w_eq;
    logic [3:0]       w_s;
    logic             w_take;
    logic [Width-1:0] w_shifted;

    // A stage shifts only when its s+1 top bits are all equal, so no significant bit is lost.
    assign w_eq[3] = (&r_data[Width-1:Width-9]) | ~(|r_data[Width-1:Width-9]);
    assign w_eq[2] = (&r_data[Width-1:Width-5]) | ~(|r_data[Width-1:Width-5]);
    assign w_eq[1] = (&r_data[Width-1:Width-3]) | ~(|r_data[Width-1:Width-3]);
    assign w_eq[0] = (&r_data[Width-1:Width-2]) | ~(|r_data[Width-1:Width-2]);

    always_comb begin
        w_s       = 4'd1 << r_k;
        w_take    = w_eq[r_k];
        w_shifted = r_data << w_s;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_k      <= 2'd0;
            r_data   <= '0;
            r_amount <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_data   <= bus.x_i;
                        r_amount <= 4'd0;
                        r_k      <= 2'd3;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_take) begin
                        r_data   <= w_shifted;
                        r_amount <= r_amount + w_s;
                    end
                    if (r_k == 2'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k - 2'd1;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o  = (r_state == S_IDLE);
    assign bus.valid_o  = (r_state == S_DONE);
    assign bus.y_o      = r_data;
    assign bus.amount_o = r_amount;
    assign bus.norm_o   = r_data[Width-1] ^ r_data[Width-2];
endmodule

// File: tb/tb_cordic_normalizer.sv
// Randomized bench for cordic_normalizer at Width 16 and 24 against a counting reference model.
module tb_cordic_normalizer;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cordic_normalizer_if #(.Width(16)) bus16 ();
    cordic_normalizer_if #(.Width(24)) bus24 ();

    cordic_normalizer #(.Width(16)) u_dut16 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus16));
    cordic_normalizer #(.Width(24)) u_dut24 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus24));

    int n_checks = 0;
    int n_errors = 0;
    int n_in16 = 0, n_out16 = 0, n_in24 = 0, n_out24 = 0;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (bus16.valid_i && bus16.ready_o) n_in16  <= n_in16 + 1;
            if (bus16.valid_o && bus16.ready_i) n_out16 <= n_out16 + 1;
            if (bus24.valid_i && bus24.ready_o) n_in24  <= n_in24 + 1;
            if (bus24.valid_o && bus24.ready_i) n_out24 <= n_out24 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = v << (32 - w);
        return t >>> (32 - w);
    endfunction

    // Count bits below the MSB that repeat it, saturate at 15, then shift left by that count.
    function automatic void ref_norm(input logic [31:0] x, input int w,
                                     output logic [31:0] y, output int amt);
        int  r;
        bit  stop;
        r = 0;
        stop = 0;
        for (int i = w - 2; i >= 0; i--) begin
            if (!stop) begin
                if (x[i] == x[w-1]) r++;
                else stop = 1;
            end
        end
        amt = (r > 15) ? 15 : r;
        y = (x << amt) & wmask(w);
    endfunction

    function automatic logic [31:0] rnd_operand(input int w);
        logic signed [31:0] r;
        r = $urandom;
        r = r >>> $urandom_range(0, 31);
        return r & wmask(w);
    endfunction

    task automatic xact16(input logic [15:0] x, input int hold, input bit noise);
        logic [31:0]        ey;
        int                 ea;
        int                 lat;
        logic signed [31:0] ys;
        ref_norm({16'h0, x}, 16, ey, ea);
        lat = 0;
        while (!bus16.ready_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("ready_idle16", bus16.ready_o, 1);
        bus16.x_i     = x;
        bus16.valid_i = 1'b1;
        bus16.ready_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        check("ready_busy16", bus16.ready_o, 0);
        if (noise) bus16.x_i = 16'h1234;
        else begin
            bus16.valid_i = 1'b0;
            bus16.x_i     = 16'($urandom);
        end
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
        end while (!bus16.valid_o && lat < 20);
        check("latency16", lat, 4);
        if (hold == 0) bus16.valid_i = 1'b0;
        bus16.ready_i = (hold == 0);
        check("y16", bus16.y_o, ey);
        check("amount16", bus16.amount_o, ea);
        check("norm16", bus16.norm_o, ey[15] ^ ey[14]);
        ys = sext(bus16.y_o, 16);
        check("roundtrip16", ys >>> bus16.amount_o, sext(x, 16));
        if (bus16.amount_o < 15) check("norm_lt15_16", bus16.norm_o, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            check("bp_valid16", bus16.valid_o, 1);
            check("bp_ready16", bus16.ready_o, 0);
            check("bp_y16", bus16.y_o, ey);
            check("bp_amount16", bus16.amount_o, ea);
            check("bp_norm16", bus16.norm_o, ey[15] ^ ey[14]);
        end
        bus16.valid_i = 1'b0;
        bus16.ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_ready16", bus16.ready_o, 1);
        check("post_valid16", bus16.valid_o, 0);
        bus16.ready_i = 1'b0;
    endtask

    task automatic xact24(input logic [23:0] x, input int hold);
        logic [31:0]        ey;
        int                 ea;
        int                 lat;
        logic signed [31:0] ys;
        ref_norm({8'h0, x}, 24, ey, ea);
        lat = 0;
        while (!bus24.ready_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("ready_idle24", bus24.ready_o, 1);
        bus24.x_i     = x;
        bus24.valid_i = 1'b1;
        bus24.ready_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        bus24.valid_i = 1'b0;
        bus24.x_i     = 24'($urandom);
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
        end while (!bus24.valid_o && lat < 20);
        check("latency24", lat, 4);
        bus24.ready_i = (hold == 0);
        check("y24", bus24.y_o, ey);
        check("amount24", bus24.amount_o, ea);
        check("norm24", bus24.norm_o, ey[23] ^ ey[22]);
        ys = sext(bus24.y_o, 24);
        check("roundtrip24", ys >>> bus24.amount_o, sext(x, 24));
        if (bus24.amount_o < 15) check("norm_lt15_24", bus24.norm_o, 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            check("bp_y24", bus24.y_o, ey);
        end
        bus24.ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_valid24", bus24.valid_o, 0);
        bus24.ready_i = 1'b0;
    endtask

    logic [15:0] dir_x [7] = '{16'h0001, 16'hFF00, 16'hFFFE, 16'h4000, 16'h8000, 16'h0000, 16'hFFFF};
    int          dir_h [7] = '{0, 5, 0, 1, 0, 0, 2};

    initial begin
        bus16.x_i = '0; bus16.valid_i = 1'b0; bus16.ready_i = 1'b0;
        bus24.x_i = '0; bus24.valid_i = 1'b0; bus24.ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", bus16.ready_o, 1);
        check("rst_valid", bus16.valid_o, 0);
        check("rst_y", bus16.y_o, 0);
        check("rst_amount", bus16.amount_o, 0);
        check("rst_norm", bus16.norm_o, 0);
        check("rst_ready24", bus24.ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) xact16(dir_x[i], dir_h[i], dir_h[i] > 0);

        // Reset while BUSY after the second stage edge.
        bus16.x_i = 16'h5555; bus16.valid_i = 1'b1;
        @(posedge clk_i); #1;
        bus16.valid_i = 1'b0; bus16.ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", bus16.ready_o, 1);
        check("midrst_valid", bus16.valid_o, 0);
        check("midrst_y", bus16.y_o, 0);
        check("midrst_amount", bus16.amount_o, 0);
        check("midrst_norm", bus16.norm_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            check("midrst_hold_valid", bus16.valid_o, 0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            check("postrst_valid", bus16.valid_o, 0);
        end
        bus16.ready_i = 1'b0;
        xact16(16'h0003, 0, 0);

        repeat (1000) xact16(16'(rnd_operand(16)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        @(posedge clk_i); #1;
        check("xact_count16", n_out16, n_in16 - 1);

        repeat (1000) xact24(24'(rnd_operand(24)), $urandom_range(0, 2));
        @(posedge clk_i); #1;
        check("xact_count24", n_out24, n_in24);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
